uart_tx_arbiter: RTL

- Round-robin scheduler that shares one COREUART transmitter among NUM_REQ byte producers.
- Each producer offers bytes on a valid/ready handshake. The arbiter selects one byte at a time and writes it into the UART host write port (CSN/WEN/DATA_IN) when TXRDY allows.
- Sits between on-chip producers (debug console, status reporter, interrupt logger, ...) and the UART core's register-side interface.

---
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one COREUART transmitter
// among NUM_REQ byte producers. Each grant yields one write strobe on the
// UART host port, followed by a POST_WR_WAIT hold-off so that TXRDY has
// time to reflect the new byte before the next decision.
//
// Optional build macro UART_ARB_LOCK_EN: adds req_last and keeps
// multi-byte messages from one requester contiguous on the line.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int POST_WR_WAIT = 2
) (
   input  logic                                          CLK,
   input  logic                                          RESET,
   input  logic [NUM_REQ-1:0]                            req_valid,
   input  logic [8*NUM_REQ-1:0]                          req_data,
`ifdef UART_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]                            req_last,
`endif
   output logic [NUM_REQ-1:0]                            req_ready,
   output logic                                          uart_csn,
   output logic                                          uart_wen,
   output logic [7:0]                                    uart_data,
   input  logic                                          uart_txrdy,
   output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
   output logic                                          busy
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PW:0] NREQ_W = (PW+1)'(NUM_REQ);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   logic [1:0]         state_reg;
   logic [3:0]         hold_cnt_reg;
   logic [PW-1:0]      ptr_reg;
   logic [7:0]         data_reg;
   logic [NUM_REQ-1:0] ready_reg;
   logic               csn_reg;
   logic               wen_reg;
   logic               busy_reg;

   logic [NUM_REQ-1:0] eligible;
   logic               win_found;
   logic [PW-1:0]      win_idx;
   logic [PW:0]        cand;
   logic [7:0]         req_byte [NUM_REQ];

   // Split the flat data bus into one byte per requester.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
         assign req_byte[gi] = req_data[8*gi +: 8];
      end
   endgenerate

`ifdef UART_ARB_LOCK_EN
   logic               lock_reg;
   logic [NUM_REQ-1:0] ptr_onehot;

   // While locked, only the owner of the open message may be granted.
   assign ptr_onehot = NUM_REQ'(1) << ptr_reg;
   assign eligible   = lock_reg ? (req_valid & ptr_onehot) : req_valid;
`else
   assign eligible   = req_valid;
`endif

   // Winner search: nearest eligible requester after ptr, wrapping around.
   // Scanning from farthest to nearest lets the nearest overwrite the rest.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_reg;
      cand      = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = {1'b0, ptr_reg} + (PW+1)'(k);
         if (cand >= NREQ_W) begin
            cand = cand - NREQ_W;
         end
         if (eligible[cand[PW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[PW-1:0];
         end
      end
   end

   // Arbitration FSM: IDLE decides, WRITE strobes for one cycle, HOLD waits.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg    <= ST_IDLE;
         hold_cnt_reg <= '0;
         ptr_reg      <= PW'(NUM_REQ - 1);
         data_reg     <= '0;
         ready_reg    <= '0;
         csn_reg      <= 1'b1;
         wen_reg      <= 1'b1;
         busy_reg     <= 1'b0;
`ifdef UART_ARB_LOCK_EN
         lock_reg     <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (uart_txrdy && win_found) begin
                  data_reg  <= req_byte[win_idx];
                  ptr_reg   <= win_idx;
                  ready_reg <= NUM_REQ'(1) << win_idx;
                  csn_reg   <= 1'b0;
                  wen_reg   <= 1'b0;
                  busy_reg  <= 1'b1;
                  state_reg <= ST_WRITE;
`ifdef UART_ARB_LOCK_EN
                  // The lock is decided at grant time from the byte's last flag.
                  lock_reg  <= ~req_last[win_idx];
`endif
               end
            end
            ST_WRITE: begin
               csn_reg      <= 1'b1;
               wen_reg      <= 1'b1;
               ready_reg    <= '0;
               hold_cnt_reg <= 4'(POST_WR_WAIT);
               state_reg    <= ST_HOLD;
            end
            ST_HOLD: begin
               if (hold_cnt_reg == 4'd1) begin
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end else begin
                  hold_cnt_reg <= hold_cnt_reg - 4'd1;
               end
            end
            default: begin
               csn_reg   <= 1'b1;
               wen_reg   <= 1'b1;
               ready_reg <= '0;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready = ready_reg;
   assign uart_csn  = csn_reg;
   assign uart_wen  = wen_reg;
   assign uart_data = data_reg;
   assign grant_id  = ptr_reg;
   assign busy      = busy_reg;

endmodule
